// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store at a time,
// stall while in flight, done/err pulses, misaligned word accesses rejected.
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err
);

  // state | meaning
  // IDLE  | ready; a request is accepted when enable=1
  // BUSY  | access in flight; cnt counts down to the completing edge
  typedef enum logic {IDLE, BUSY} state_t;

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [15:0]         wdata_q;
  logic [15:0]         data_out_q;
  logic                done_q;
  logic                err_q;
  logic [15:0]         mem_q [DEPTH];

  logic                accept;
  logic                acc_en;
  logic                acc_wr;
  logic [ADDR_W-1:0]   acc_idx;
  logic [15:0]         acc_data;

  // Byte-address bits above the word index only alias; they are not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[15:ADDR_W+1];

  // With LATENCY=1 the access uses the live request, otherwise the latched one.
  always_comb begin
    accept   = (state_q == IDLE) && enable;
    acc_en   = 1'b0;
    acc_wr   = wr_q;
    acc_idx  = idx_q;
    acc_data = wdata_q;
    if (accept && !addr[0] && (LATENCY == 1)) begin
      acc_en   = 1'b1;
      acc_wr   = wr;
      acc_idx  = addr[ADDR_W:1];
      acc_data = data_in;
    end else if ((state_q == BUSY) && (cnt_q == 4'd0)) begin
      acc_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        wr_q    <= wr;
        idx_q   <= addr[ADDR_W:1];
        wdata_q <= data_in;
        if (addr[0]) begin
          err_q <= 1'b1;
        end else if (LATENCY > 1) begin
          state_q <= BUSY;
          cnt_q   <= CNT_INIT;
        end
      end
      if (state_q == BUSY) begin
        if (cnt_q == 4'd0) state_q <= IDLE;
        else               cnt_q   <= cnt_q - 4'd1;
      end
      if (acc_en) begin
        done_q <= 1'b1;
        if (acc_wr) mem_q[acc_idx] <= acc_data;
        else        data_out_q     <= mem_q[acc_idx];
      end
    end
  end

  assign data_out = data_out_q;
  assign done     = done_q;
  assign err      = err_q;
  assign stall    = (state_q == BUSY);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=3 and a LATENCY=1 instance checked
// every cycle against a transaction-level model, plus hand-computed literals.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        en   [2];
  logic        wr_s [2];
  logic [15:0] ad   [2];
  logic [15:0] di   [2];
  logic [15:0] dout [2];
  logic        done_s  [2];
  logic        stall_s [2];
  logic        err_s   [2];

  int n_tests;
  int n_fail;
  int cyc;

  // model state: k=0 is the LATENCY=3 instance, k=1 the LATENCY=1 instance
  logic [15:0] m_mem [2][256];
  int          m_free [2];
  int          m_pc   [2];
  bit          m_pv   [2];
  bit          m_pw   [2];
  int          m_pidx [2];
  logic [15:0] m_pd   [2];
  logic [15:0] m_dout [2];
  bit          m_done [2];
  bit          m_err  [2];
  bit          m_stall[2];

  data_mem_responder #(.ADDR_W(8), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .enable(en[0]), .wr(wr_s[0]), .addr(ad[0]),
    .data_in(di[0]), .data_out(dout[0]), .done(done_s[0]),
    .stall(stall_s[0]), .err(err_s[0])
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .enable(en[1]), .wr(wr_s[1]), .addr(ad[1]),
    .data_in(di[1]), .data_out(dout[1]), .done(done_s[1]),
    .stall(stall_s[1]), .err(err_s[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    chk(name, {15'd0, got}, {15'd0, exp});
  endtask

  task automatic model_reset(input int k);
    for (int i = 0; i < 256; i++) m_mem[k][i] = 16'h0000;
    m_free[k]  = 0;
    m_pc[k]    = 0;
    m_pv[k]    = 1'b0;
    m_pw[k]    = 1'b0;
    m_pidx[k]  = 0;
    m_pd[k]    = 16'h0000;
    m_dout[k]  = 16'h0000;
    m_done[k]  = 1'b0;
    m_err[k]   = 1'b0;
    m_stall[k] = 1'b0;
  endtask

  // Advance the model across one rising edge: decide what the next cycle shows.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        model_reset(k);
      end else begin
        m_done[k] = 1'b0;
        m_err[k]  = 1'b0;
        if (en[k] && (cyc >= m_free[k])) begin
          if (ad[k][0]) begin
            m_err[k] = 1'b1;
          end else begin
            m_pv[k]   = 1'b1;
            m_pw[k]   = wr_s[k];
            m_pidx[k] = int'(ad[k][8:1]);
            m_pd[k]   = di[k];
            m_pc[k]   = cyc + lat(k);
            m_free[k] = cyc + lat(k);
          end
        end
        if (m_pv[k] && (m_pc[k] == cyc + 1)) begin
          if (m_pw[k]) m_mem[k][m_pidx[k]] = m_pd[k];
          else         m_dout[k] = m_mem[k][m_pidx[k]];
          m_done[k] = 1'b1;
          m_pv[k]   = 1'b0;
        end
        m_stall[k] = (cyc + 1 < m_free[k]);
      end
    end
    cyc++;
  endtask

  task automatic model_compare();
    for (int k = 0; k < 2; k++) begin
      string p;
      p = (k == 0) ? "L3" : "L1";
      if (!rst) begin
        chk({p, ".rst.data_out"}, dout[k], 16'h0000);
        chk1({p, ".rst.done"}, done_s[k], 1'b0);
        chk1({p, ".rst.stall"}, stall_s[k], 1'b0);
        chk1({p, ".rst.err"}, err_s[k], 1'b0);
      end else begin
        chk({p, ".data_out"}, dout[k], m_dout[k]);
        chk1({p, ".done"}, done_s[k], m_done[k]);
        chk1({p, ".stall"}, stall_s[k], m_stall[k]);
        chk1({p, ".err"}, err_s[k], m_err[k]);
      end
    end
  endtask

  // One cycle: compare at the falling edge, step the model at the rising edge,
  // return 2ns into the new cycle where stimulus is applied.
  task automatic tick();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic req(input int k, input logic w, input logic [15:0] a, input logic [15:0] d);
    en[k]   = 1'b1;
    wr_s[k] = w;
    ad[k]   = a;
    di[k]   = d;
    tick();
    en[k] = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; wr_s[k] = 1'b0; ad[k] = 16'h0000; di[k] = 16'h0000;
      model_reset(k);
    end
    repeat (3) tick();
    chk("reset.stall", {15'd0, stall_s[0]}, 16'h0000);
    chk("reset.data_out", dout[0], 16'h0000);
    rst = 1'b1;
    tick();

    // 1: read of a reset word
    req(0, 1'b0, 16'h0010, 16'h0000);
    chk1("t1.stall_T+1", stall_s[0], 1'b1);
    tick();
    chk1("t1.stall_T+2", stall_s[0], 1'b1);
    tick();
    chk1("t1.done_T+3", done_s[0], 1'b1);
    chk1("t1.stall_T+3", stall_s[0], 1'b0);
    chk("t1.data_out", dout[0], 16'h0000);

    // 2: write then read issued in the write's done cycle
    req(0, 1'b1, 16'h0020, 16'hBEEF);
    tick();
    tick();
    chk1("t2.wr_done", done_s[0], 1'b1);
    chk1("t2.wr_done_stall", stall_s[0], 1'b0);
    req(0, 1'b0, 16'h0020, 16'h0000);
    tick();
    tick();
    chk1("t2.rd_done", done_s[0], 1'b1);
    chk("t2.rd_data", dout[0], 16'hBEEF);

    // 3: misaligned write rejected, old word survives
    req(0, 1'b1, 16'h0202, 16'h1357);
    tick();
    tick();
    req(0, 1'b1, 16'h0203, 16'hFFFF);
    chk1("t3.err", err_s[0], 1'b1);
    chk1("t3.err_done", done_s[0], 1'b0);
    chk1("t3.err_stall", stall_s[0], 1'b0);
    tick();
    chk1("t3.err_pulse_end", err_s[0], 1'b0);
    req(0, 1'b0, 16'h0202, 16'h0000);
    tick();
    tick();
    chk("t3.old_value", dout[0], 16'h1357);

    // 4: address aliasing above ADDR_W
    req(0, 1'b1, 16'h0204, 16'h1234);
    tick();
    tick();
    req(0, 1'b0, 16'h0004, 16'h0000);
    tick();
    tick();
    chk("t4.alias", dout[0], 16'h1234);

    // 5: reset one cycle after accepting a write aborts it
    req(0, 1'b1, 16'h0030, 16'h5555);
    rst = 1'b0;
    tick();
    chk1("t5.rst_done", done_s[0], 1'b0);
    rst = 1'b1;
    tick();
    chk1("t5.no_done_a", done_s[0], 1'b0);
    tick();
    chk1("t5.no_done_b", done_s[0], 1'b0);
    req(0, 1'b0, 16'h0030, 16'h0000);
    tick();
    tick();
    chk1("t5.rd_done", done_s[0], 1'b1);
    chk("t5.rd_data", dout[0], 16'h0000);

    // 6a: request inputs change while stalled; original read completes
    req(0, 1'b1, 16'h0204, 16'h1234);
    tick();
    tick();
    en[0] = 1'b1; wr_s[0] = 1'b0; ad[0] = 16'h0204; di[0] = 16'h0000;
    tick();
    wr_s[0] = 1'b1; ad[0] = 16'h0206; di[0] = 16'hDEAD;
    tick();
    ad[0] = 16'h0205;
    tick();
    en[0] = 1'b0;
    chk1("t6.hold_done", done_s[0], 1'b1);
    chk("t6.hold_data", dout[0], 16'h1234);
    req(0, 1'b0, 16'h0206, 16'h0000);
    tick();
    tick();
    chk("t6.ignored_write", dout[0], 16'h0000);

    // 6b: LATENCY=1 back-to-back
    req(1, 1'b1, 16'h0002, 16'h1111);
    chk1("t6.l1_wr_done_a", done_s[1], 1'b1);
    req(1, 1'b1, 16'h0004, 16'h2222);
    chk1("t6.l1_wr_done_b", done_s[1], 1'b1);
    en[1] = 1'b1; wr_s[1] = 1'b0; ad[1] = 16'h0002;
    tick();
    chk1("t6.l1_rd0_done", done_s[1], 1'b1);
    chk("t6.l1_rd0", dout[1], 16'h1111);
    ad[1] = 16'h0004;
    tick();
    chk1("t6.l1_rd1_done", done_s[1], 1'b1);
    chk("t6.l1_rd1", dout[1], 16'h2222);
    ad[1] = 16'h0002;
    tick();
    chk1("t6.l1_rd2_done", done_s[1], 1'b1);
    chk("t6.l1_rd2", dout[1], 16'h1111);
    ad[1] = 16'h0000;
    tick();
    en[1] = 1'b0;
    chk1("t6.l1_rd3_done", done_s[1], 1'b1);
    chk1("t6.l1_stall", stall_s[1], 1'b0);
    chk("t6.l1_rd3", dout[1], 16'h0000);
    tick();
    chk1("t6.l1_idle_done", done_s[1], 1'b0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
